// File: rtl/operand_fetch_unit_if.sv
// Operand fetch bundle: decode request, register-file read port and execute response.
interface operand_fetch_unit_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IDX_W  = 4
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_mask;
   logic [IDX_W-1:0]  req_rn;
   logic [IDX_W-1:0]  req_rm;
   logic [IDX_W-1:0]  req_rs;
   logic [DATA_W-1:0] pc_in;
   logic              rf_rd_en;
   logic [IDX_W-1:0]  rf_rd_addr;
   logic [DATA_W-1:0] rf_rd_data;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] op_c;

   // The fetch unit itself
   modport slave (
      input  req_valid, req_mask, req_rn, req_rm, req_rs, pc_in, rf_rd_data, rsp_ready,
      output req_ready, rf_rd_en, rf_rd_addr, rsp_valid, op_a, op_b, op_c
   );

   // Decode, register file and execute side
   modport master (
      output req_valid, req_mask, req_rn, req_rm, req_rs, pc_in, rf_rd_data, rsp_ready,
      input  req_ready, rf_rd_en, rf_rd_addr, rsp_valid, op_a, op_b, op_c
   );
endinterface

// File: rtl/operand_fetch_unit.sv
// Fetches up to three register operands one per cycle through a synchronous read port.
// Optional feature macro OPF_PC_BYPASS_EN: R15 operands return latched PC_IN+8 without a read.
module operand_fetch_unit #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IDX_W  = 4
) (
   input logic                clk,
   input logic                rst_n,
   operand_fetch_unit_if.slave bus
);
   localparam int unsigned N_OPS = 3;
   localparam int unsigned TGT_W = 2;

   typedef enum logic [1:0] {IDLE, FETCH, RESP} state_e;

   state_e            state_q, state_d;
   logic [N_OPS-1:0]  pend_q, pend_d;
   logic [IDX_W-1:0]  rn_q, rn_d, rm_q, rm_d, rs_q, rs_d;
   logic              req_ready_q, req_ready_d;
   logic              rd_en_q, rd_en_d;
   logic [IDX_W-1:0]  rd_addr_q, rd_addr_d;
   logic [TGT_W-1:0]  rd_tgt_q, rd_tgt_d;
   logic              cap_en_q, cap_en_d;
   logic [TGT_W-1:0]  cap_tgt_q, cap_tgt_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;

   logic [N_OPS-1:0]  need_c;
   logic [N_OPS-1:0]  issue_src_c;
   logic [IDX_W-1:0]  src_rn_c, src_rm_c, src_rs_c;

`ifdef OPF_PC_BYPASS_EN
   localparam logic [IDX_W-1:0] PC_IDX = IDX_W'(15);
   logic [DATA_W-1:0] pc_plus8_c;
   assign pc_plus8_c = bus.pc_in + DATA_W'(8);
`endif

   // Operands of the incoming request that need a register-file read
   always_comb begin
      need_c = bus.req_mask;
`ifdef OPF_PC_BYPASS_EN
      if (bus.req_rn == PC_IDX) need_c[0] = 1'b0;
      if (bus.req_rm == PC_IDX) need_c[1] = 1'b0;
      if (bus.req_rs == PC_IDX) need_c[2] = 1'b0;
`endif
   end

   always_comb begin
      state_d     = state_q;
      rn_d        = rn_q;
      rm_d        = rm_q;
      rs_d        = rs_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_c_d      = op_c_q;
      rd_en_d     = 1'b0;
      rd_addr_d   = '0;
      rd_tgt_d    = '0;
      cap_en_d    = rd_en_q;
      cap_tgt_d   = rd_tgt_q;
      issue_src_c = '0;
      src_rn_c    = rn_q;
      src_rm_c    = rm_q;
      src_rs_c    = rs_q;

      // Read data arrives the cycle after its strobe
      if (cap_en_q) begin
         case (cap_tgt_q)
            2'd0:    op_a_d = bus.rf_rd_data;
            2'd1:    op_b_d = bus.rf_rd_data;
            default: op_c_d = bus.rf_rd_data;
         endcase
      end

      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (bus.req_valid && req_ready_q) begin
               rn_d        = bus.req_rn;
               rm_d        = bus.req_rm;
               rs_d        = bus.req_rs;
               src_rn_c    = bus.req_rn;
               src_rm_c    = bus.req_rm;
               src_rs_c    = bus.req_rs;
               req_ready_d = 1'b0;
`ifdef OPF_PC_BYPASS_EN
               op_a_d = (bus.req_mask[0] && bus.req_rn == PC_IDX) ? pc_plus8_c : '0;
               op_b_d = (bus.req_mask[1] && bus.req_rm == PC_IDX) ? pc_plus8_c : '0;
               op_c_d = (bus.req_mask[2] && bus.req_rs == PC_IDX) ? pc_plus8_c : '0;
`else
               op_a_d = '0;
               op_b_d = '0;
               op_c_d = '0;
`endif
               if (need_c == '0) begin
                  state_d = RESP;
               end else begin
                  state_d     = FETCH;
                  issue_src_c = need_c;
               end
            end
         end
         FETCH: begin
            issue_src_c = pend_q;
            if (pend_q == '0 && !rd_en_q && cap_en_q) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
            end
         end
         RESP: begin
            if (rsp_valid_q && bus.rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               op_a_d      = '0;
               op_b_d      = '0;
               op_c_d      = '0;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Issue the lowest-numbered pending operand
      pend_d = issue_src_c;
      if (issue_src_c[0]) begin
         rd_en_d   = 1'b1;
         rd_addr_d = src_rn_c;
         rd_tgt_d  = 2'd0;
         pend_d[0] = 1'b0;
      end else if (issue_src_c[1]) begin
         rd_en_d   = 1'b1;
         rd_addr_d = src_rm_c;
         rd_tgt_d  = 2'd1;
         pend_d[1] = 1'b0;
      end else if (issue_src_c[2]) begin
         rd_en_d   = 1'b1;
         rd_addr_d = src_rs_c;
         rd_tgt_d  = 2'd2;
         pend_d[2] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         rn_q        <= '0;
         rm_q        <= '0;
         rs_q        <= '0;
         req_ready_q <= 1'b1;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         rd_tgt_q    <= '0;
         cap_en_q    <= 1'b0;
         cap_tgt_q   <= '0;
         rsp_valid_q <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_c_q      <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         rn_q        <= rn_d;
         rm_q        <= rm_d;
         rs_q        <= rs_d;
         req_ready_q <= req_ready_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         rd_tgt_q    <= rd_tgt_d;
         cap_en_q    <= cap_en_d;
         cap_tgt_q   <= cap_tgt_d;
         rsp_valid_q <= rsp_valid_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_c_q      <= op_c_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.rf_rd_en   = rd_en_q;
   assign bus.rf_rd_addr = rd_addr_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.op_a       = op_a_q;
   assign bus.op_b       = op_b_q;
   assign bus.op_c       = op_c_q;
endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit with a synchronous-read register-file model.
module tb_operand_fetch_unit;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   int   addr_bad = 0;
   int   cyc;
   logic [31:0] rf_mem [16];
   logic [3:0]  rd_log [$];

   operand_fetch_unit_if bus ();

   operand_fetch_unit dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.rf_rd_en) bus.rf_rd_data <= rf_mem[bus.rf_rd_addr];
   end

   always @(negedge clk) begin
      if (bus.rf_rd_en) rd_log.push_back(bus.rf_rd_addr);
      else if (bus.rf_rd_addr !== 4'd0) addr_bad++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] mask, input logic [3:0] rn, input logic [3:0] rm,
                       input logic [3:0] rs, input logic [31:0] pc);
      bus.req_valid = 1'b1;
      bus.req_mask  = mask;
      bus.req_rn    = rn;
      bus.req_rm    = rm;
      bus.req_rs    = rs;
      bus.pc_in     = pc;
      step();
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
   endtask

   function automatic logic [31:0] log_at(input int i);
      if (i < rd_log.size()) return 32'(rd_log[i]);
      return 32'hDEAD_BEEF;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 16; i++) rf_mem[i] = 32'hA000_0000 + 32'(i);
      rf_mem[2] = 32'h11;
      rf_mem[5] = 32'h22;
      bus.req_valid = 1'b0;
      bus.req_mask  = 3'b000;
      bus.req_rn    = 4'd0;
      bus.req_rm    = 4'd0;
      bus.req_rs    = 4'd0;
      bus.pc_in     = 32'd0;
      bus.rsp_ready = 1'b1;
      rst_n = 1'b0;
      #12;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rd_en", 32'(bus.rf_rd_en), 32'd0);
      chk("rst_rd_addr", 32'(bus.rf_rd_addr), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_op_a", bus.op_a, 32'd0);
      chk("rst_op_b", bus.op_b, 32'd0);
      chk("rst_op_c", bus.op_c, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      step();

      // Two reads, Rn then Rm
      rd_log.delete();
      send(3'b011, 4'd2, 4'd5, 4'd0, 32'd0);
      chk("t1_en_c1", 32'(bus.rf_rd_en), 32'd1);
      chk("t1_addr_c1", 32'(bus.rf_rd_addr), 32'd2);
      chk("t1_req_ready", 32'(bus.req_ready), 32'd0);
      step();
      chk("t1_en_c2", 32'(bus.rf_rd_en), 32'd1);
      chk("t1_addr_c2", 32'(bus.rf_rd_addr), 32'd5);
      step();
      chk("t1_en_c3", 32'(bus.rf_rd_en), 32'd0);
      chk("t1_addr_c3", 32'(bus.rf_rd_addr), 32'd0);
      chk("t1_rsp_early", 32'(bus.rsp_valid), 32'd0);
      step();
      chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("t1_op_a", bus.op_a, 32'h11);
      chk("t1_op_b", bus.op_b, 32'h22);
      chk("t1_op_c", bus.op_c, 32'h0);
      step();
      chk("t1_rsp_done", 32'(bus.rsp_valid), 32'd0);
      chk("t1_req_ready", 32'(bus.req_ready), 32'd1);
      chk("t1_nreads", 32'(rd_log.size()), 32'd2);
      chk("t1_rd0", log_at(0), 32'd2);
      chk("t1_rd1", log_at(1), 32'd5);

      // Backpressure on a three-read request
      bus.rsp_ready = 1'b0;
      send(3'b111, 4'd1, 4'd2, 4'd3, 32'd0);
      wait_rsp(cyc);
      chk("t2_latency", 32'(cyc), 32'd4);
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", 32'(bus.rsp_valid), 32'd1);
         chk("t2_hold_op_a", bus.op_a, 32'hA000_0001);
         chk("t2_hold_op_b", bus.op_b, 32'h11);
         chk("t2_hold_op_c", bus.op_c, 32'hA000_0003);
         chk("t2_hold_req_ready", 32'(bus.req_ready), 32'd0);
         step();
      end
      bus.rsp_ready = 1'b1;
      chk("t2_hs_req_ready", 32'(bus.req_ready), 32'd0);
      step();
      chk("t2_after_valid", 32'(bus.rsp_valid), 32'd0);
      chk("t2_after_req_ready", 32'(bus.req_ready), 32'd1);

      // Empty mask
      rd_log.delete();
      send(3'b000, 4'd3, 4'd4, 4'd5, 32'd0);
      chk("t3_rsp_early", 32'(bus.rsp_valid), 32'd0);
      wait_rsp(cyc);
      chk("t3_latency", 32'(cyc), 32'd1);
      chk("t3_op_a", bus.op_a, 32'd0);
      chk("t3_op_b", bus.op_b, 32'd0);
      chk("t3_op_c", bus.op_c, 32'd0);
      step();
      chk("t3_rsp_done", 32'(bus.rsp_valid), 32'd0);
      chk("t3_nreads", 32'(rd_log.size()), 32'd0);

      // R15 with PC near wrap
      rd_log.delete();
      send(3'b011, 4'd15, 4'd4, 4'd0, 32'hFFFF_FFFC);
      wait_rsp(cyc);
`ifdef OPF_PC_BYPASS_EN
      chk("t4_latency", 32'(cyc), 32'd2);
      chk("t4_op_a", bus.op_a, 32'h0000_0004);
      chk("t4_nreads", 32'(rd_log.size()), 32'd1);
      chk("t4_rd0", log_at(0), 32'd4);
`else
      chk("t4_latency", 32'(cyc), 32'd3);
      chk("t4_op_a", bus.op_a, 32'hA000_000F);
      chk("t4_nreads", 32'(rd_log.size()), 32'd2);
      chk("t4_rd0", log_at(0), 32'd15);
      chk("t4_rd1", log_at(1), 32'd4);
`endif
      chk("t4_op_b", bus.op_b, 32'hA000_0004);
      chk("t4_op_c", bus.op_c, 32'd0);
      step();

      // Asynchronous reset during the second read
      send(3'b111, 4'd1, 4'd2, 4'd3, 32'd0);
      step();
      chk("t5_en_c2", 32'(bus.rf_rd_en), 32'd1);
      chk("t5_addr_c2", 32'(bus.rf_rd_addr), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_en", 32'(bus.rf_rd_en), 32'd0);
      chk("t5_rst_addr", 32'(bus.rf_rd_addr), 32'd0);
      chk("t5_rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("t5_rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("t5_rst_op_a", bus.op_a, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      step();
      chk("t5_idle_req_ready", 32'(bus.req_ready), 32'd1);
      chk("t5_idle_valid", 32'(bus.rsp_valid), 32'd0);
      rd_log.delete();
      send(3'b001, 4'd7, 4'd0, 4'd0, 32'd0);
      wait_rsp(cyc);
      chk("t5_latency", 32'(cyc), 32'd2);
      chk("t5_op_a", bus.op_a, 32'hA000_0007);
      chk("t5_op_b", bus.op_b, 32'd0);
      chk("t5_op_c", bus.op_c, 32'd0);
      chk("t5_nreads", 32'(rd_log.size()), 32'd1);
      chk("t5_rd0", log_at(0), 32'd7);
      step();

      // Request presented mid-FETCH must be ignored
      rd_log.delete();
      send(3'b001, 4'd9, 4'd0, 4'd0, 32'd0);
      bus.req_valid = 1'b1;
      bus.req_mask  = 3'b111;
      bus.req_rn    = 4'd10;
      bus.req_rm    = 4'd11;
      bus.req_rs    = 4'd12;
      step();
      bus.req_valid = 1'b0;
      wait_rsp(cyc);
      chk("t6_latency", 32'(cyc), 32'd1);
      chk("t6_op_a", bus.op_a, 32'hA000_0009);
      chk("t6_op_b", bus.op_b, 32'd0);
      chk("t6_op_c", bus.op_c, 32'd0);
      chk("t6_nreads", 32'(rd_log.size()), 32'd1);
      chk("t6_rd0", log_at(0), 32'd9);
      step();
      step();
      chk("t6_idle_en", 32'(bus.rf_rd_en), 32'd0);
      chk("t6_idle_valid", 32'(bus.rsp_valid), 32'd0);
      chk("t6_idle_req_ready", 32'(bus.req_ready), 32'd1);

      chk("addr_zero_when_idle", 32'(addr_bad), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
